// File: rtl/dequant_arbiter.sv
// Two-requester round-robin burst arbiter feeding a signed int8 dequantizer.
// Each grant accepts exactly BURST_LEN elements, then drains for one cycle.
module dequant_arbiter #(
    parameter int unsigned SCALE     = 2408,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [1:0]         req_i,
    output logic [1:0]         gnt_o,
    input  logic signed [7:0]  din0_i,
    input  logic signed [7:0]  din1_i,
    input  logic               valid0_i,
    input  logic               valid1_i,
    output logic signed [31:0] dout_o,
    output logic               valid_o,
    output logic               id_o,
    output logic               done_o,
    output logic               busy_o
);

    localparam int unsigned CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
    localparam logic signed [31:0] SCALE_S = $signed(32'(SCALE));

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic               idx;
    logic               idx_nxt;
    logic               ptr;
    logic               accept;
    logic               last;
    logic               vld_sel;
    logic signed [7:0]  din_sel;
    logic signed [31:0] product;

    always_comb begin
        vld_sel = idx ? valid1_i : valid0_i;
        din_sel = idx ? din1_i : din0_i;
        accept  = (state == BURST) && vld_sel;
        last    = accept && (cnt == LAST);
        product = 32'(din_sel) * SCALE_S;
        // ptr holds the index favoured when both request
        unique case (req_i)
            2'b01:   idx_nxt = 1'b0;
            2'b10:   idx_nxt = 1'b1;
            default: idx_nxt = ptr;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_i != '0) state_nxt = BURST;
            BURST:   if (last) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_o  = '0;
        busy_o = (state != IDLE);
        if (state == BURST) gnt_o = idx ? 2'b10 : 2'b01;
    end

    // Counter holds at LAST on the final accept and is cleared in DRAIN
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt <= '0;
            idx <= 1'b0;
            ptr <= 1'b0;
        end else begin
            unique case (state)
                IDLE:    if (req_i != '0) idx <= idx_nxt;
                BURST:   if (accept && !last) cnt <= cnt + CW'(1);
                DRAIN: begin
                    ptr <= ~idx;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            dout_o  <= '0;
            valid_o <= 1'b0;
            id_o    <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            valid_o <= accept;
            done_o  <= last;
            if (accept) begin
                dout_o <= product;
                id_o   <= idx;
            end
        end
    end

endmodule

// File: tb/tb_dequant_arbiter.sv
// Directed bench for dequant_arbiter: table-driven bursts plus arbitration and reset sequences.
module tb_dequant_arbiter;

    logic               clk = 1'b0;
    logic               rstn;
    logic [1:0]         req;
    logic [1:0]         gnt;
    logic signed [7:0]  d0, d1;
    logic               v0, v1;
    logic signed [31:0] dout;
    logic               valid, id, done, busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] held = '0;

    typedef struct {
        logic signed [7:0]  din;
        logic signed [31:0] dout;
        bit                 gap;
    } vec_t;

    vec_t vecs [16];

    dequant_arbiter #(.SCALE(2408), .BURST_LEN(8)) dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .gnt_o(gnt),
        .din0_i(d0), .din1_i(d1), .valid0_i(v0), .valid1_i(v1),
        .dout_o(dout), .valid_o(valid), .id_o(id), .done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [1:0] e_gnt, input logic e_valid,
                             input logic [31:0] e_dout, input logic e_id, input logic e_done,
                             input logic e_busy);
        check({name, ".gnt"},   32'(gnt),   32'(e_gnt));
        check({name, ".valid"}, 32'(valid), 32'(e_valid));
        check({name, ".dout"},  dout,       e_dout);
        check({name, ".id"},    32'(id),    32'(e_id));
        check({name, ".done"},  32'(done),  32'(e_done));
        check({name, ".busy"},  32'(busy),  32'(e_busy));
    endtask

    // Both requesters drive distinct valid data every cycle; only the granted one may appear
    task automatic run_burst(input int who);
        int e;
        for (int k = 0; k < 8; k++) begin
            d0 = 8'(k + 1);
            d1 = 8'(-(k + 10));
            v0 = 1'b1;
            v1 = 1'b1;
            cyc();
            e = (who == 1) ? -(k + 10) * 2408 : (k + 1) * 2408;
            held = 32'(e);
            check_all("burst", (k == 7) ? 2'b00 : ((who == 1) ? 2'b10 : 2'b01),
                      1'b1, held, 1'(who), k == 7, 1'b1);
        end
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    initial begin
        bit lastf;
        vecs[0]  = '{8'sd1,    32'sd2408,    1'b0};
        vecs[1]  = '{8'sd2,    32'sd4816,    1'b0};
        vecs[2]  = '{8'sd3,    32'sd7224,    1'b0};
        vecs[3]  = '{8'sd4,    32'sd9632,    1'b0};
        vecs[4]  = '{8'sd5,    32'sd12040,   1'b0};
        vecs[5]  = '{8'sd6,    32'sd14448,   1'b0};
        vecs[6]  = '{8'sd7,    32'sd16856,   1'b0};
        vecs[7]  = '{8'sd8,    32'sd19264,   1'b0};
        vecs[8]  = '{-8'sd128, -32'sd308224, 1'b0};
        vecs[9]  = '{8'sd127,  32'sd305816,  1'b1};
        vecs[10] = '{8'sd0,    32'sd0,       1'b0};
        vecs[11] = '{-8'sd1,   -32'sd2408,   1'b1};
        vecs[12] = '{8'sd64,   32'sd154112,  1'b0};
        vecs[13] = '{-8'sd64,  -32'sd154112, 1'b1};
        vecs[14] = '{8'sd100,  32'sd240800,  1'b0};
        vecs[15] = '{-8'sd100, -32'sd240800, 1'b0};

        rstn = 1'b0; req = '0; d0 = '0; d1 = '0; v0 = 1'b0; v1 = 1'b0;
        cyc();
        cyc();
        check_all("reset", 2'b00, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        cyc();
        check_all("idle", 2'b00, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Two bursts from requester 0; the second has valid gaps while requester 1 pushes -128
        for (int i = 0; i < 16; i++) begin
            if (i % 8 == 0) begin
                req = 2'b01;
                if (i == 8) begin
                    v1 = 1'b1;
                    d1 = -8'sd128;
                end
                cyc();
                check_all("grant", 2'b01, 1'b0, held, 1'b0, 1'b0, 1'b1);
                req = 2'b00;
            end
            if (vecs[i].gap) begin
                v0 = 1'b0;
                d0 = 8'sd99;
                cyc();
                check_all("gap", 2'b01, 1'b0, held, 1'b0, 1'b0, 1'b1);
            end
            v0 = 1'b1;
            d0 = vecs[i].din;
            cyc();
            lastf = (i % 8 == 7);
            held = vecs[i].dout;
            check_all("elem", lastf ? 2'b00 : 2'b01, 1'b1, held, 1'b0, lastf, 1'b1);
            if (lastf) begin
                v0 = 1'b0;
                cyc();
                check_all("after", 2'b00, 1'b0, held, 1'b0, 1'b0, 1'b0);
            end
        end
        v1 = 1'b0;

        // Round-robin with both requesting continuously
        rstn = 1'b0;
        cyc();
        held = '0;
        check_all("reset2", 2'b00, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        req = 2'b11;
        cyc();
        check_all("rr_g0", 2'b01, 1'b0, held, 1'b0, 1'b0, 1'b1);
        run_burst(0);
        cyc();
        check_all("rr_gap1", 2'b00, 1'b0, held, 1'b0, 1'b0, 1'b0);
        cyc();
        check_all("rr_g1", 2'b10, 1'b0, held, 1'b0, 1'b0, 1'b1);
        run_burst(1);
        cyc();
        check_all("rr_gap2", 2'b00, 1'b0, held, 1'b1, 1'b0, 1'b0);
        cyc();
        check_all("rr_g0b", 2'b01, 1'b0, held, 1'b1, 1'b0, 1'b1);
        req = 2'b00;
        run_burst(0);
        cyc();
        check_all("rr_end", 2'b00, 1'b0, held, 1'b0, 1'b0, 1'b0);

        // Reset after four accepted elements abandons the burst
        req = 2'b01;
        cyc();
        check_all("mr_g", 2'b01, 1'b0, held, 1'b0, 1'b0, 1'b1);
        req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            v0 = 1'b1;
            d0 = 8'(k + 1);
            cyc();
            held = 32'((k + 1) * 2408);
            check_all("mr_elem", 2'b01, 1'b1, held, 1'b0, 1'b0, 1'b1);
        end
        rstn = 1'b0;
        req = 2'b10;
        cyc();
        held = '0;
        check_all("mr_reset", 2'b00, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        v0 = 1'b0;
        cyc();
        check_all("mr_g1", 2'b10, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        req = 2'b00;
        run_burst(1);
        cyc();
        check_all("mr_end", 2'b00, 1'b0, held, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dequant_arbiter.md
DEQUANT_ARBITER -- requirements
Module: dequant_arbiter

Interface
REQ-001 Parameter SCALE, default 2408, SHALL be the unsigned dequantization scale factor, legal range 1..2^23-1.
REQ-002 Parameter BURST_LEN, default 8, SHALL be the number of elements per granted burst, legal range 2..256.
REQ-003 clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rstn_i  in  1  SHALL be the reset, synchronous and active-low.
REQ-005 req_i  in  2  SHALL carry burst requests; bit r is requester r.
REQ-006 gnt_o  out  2  SHALL be the one-hot grant, held for the whole burst.
REQ-007 din0_i, din1_i  in  8 each  SHALL be the signed int8 data from requesters 0 and 1.
REQ-008 valid0_i, valid1_i  in  1 each  SHALL qualify din0_i and din1_i.
REQ-009 dout_o  out  32  SHALL be the signed dequantized result.
REQ-010 valid_o  out  1  SHALL qualify dout_o, id_o and done_o.
REQ-011 id_o  out  1  SHALL tag the requester that owns dout_o.
REQ-012 done_o  out  1  SHALL pulse with the last element of each burst.
REQ-013 busy_o  out  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, BURST and DRAIN; busy_o = (state != IDLE).
REQ-015 IDLE: if req_i != 0, the block SHALL register a grant and enter BURST, so gnt_o is high in the cycle after req_i is sampled.
REQ-016 Arbitration SHALL be round-robin. With a single requester, that requester wins. With both requesting, the requester not served last wins. The pointer favours requester 0 after reset.
REQ-017 BURST: each cycle the granted requester's valid is high, its din SHALL be accepted and the element counter incremented; valid_o is high with the result one cycle later.
REQ-018 Valid and data from the non-granted requester SHALL be ignored; valid gaps from the granted requester SHALL be allowed with no timeout.
REQ-019 Deassertion of req_i during BURST SHALL NOT end the burst; exactly BURST_LEN elements are accepted per grant.
REQ-020 Acceptance of element BURST_LEN-1 SHALL move the FSM to DRAIN; gnt_o is 0 in DRAIN.
REQ-021 DRAIN SHALL last exactly one cycle and present the last result with valid_o=1 and done_o=1. It then updates the round-robin pointer, clears the counter and returns to IDLE.
REQ-022 Back-to-back bursts SHALL incur a minimum of two cycles with gnt_o=0 between the last accept and the next grant (the DRAIN and IDLE cycles).
REQ-023 dout_o SHALL equal sign-extended din times SCALE, computed exactly in 32-bit signed arithmetic, for example -128 -> -308224.
REQ-024 id_o SHALL equal the index of the granted requester for every valid output; dout_o and id_o hold their value when valid_o=0.
REQ-025 done_o SHALL only be high together with valid_o=1 and SHALL be high for exactly one cycle per burst.
REQ-026 The element counter SHALL be ceil(log2(BURST_LEN+1)) bits wide, SHALL never exceed BURST_LEN-1 and SHALL NOT wrap mid-burst.

Reset
REQ-027 While rstn_i=0 at a clock edge, the FSM SHALL enter IDLE, clear the counter and set the pointer to favour requester 0. gnt_o, dout_o, valid_o, id_o, done_o and busy_o are all 0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no done_o, and no output from that burst appears after reset release.

Verification
REQ-029 Reset, then req_i=01, then 8 valid din0 values of 1..8 on consecutive cycles -> gnt_o=01; dout_o 2408..19264 with id_o=0; done_o on the 8th output; busy_o drops after DRAIN.
REQ-030 req_i=11 held for two bursts -> first grant to 0, second to 1, then back to 0; the gap between bursts is at least two cycles with gnt_o=0.
REQ-031 Granted requester 0 with valid gaps while valid1_i=1 with din1_i=-128 throughout -> only requester-0 data appears; exactly 8 outputs, with none equal to -308224 unless sent by requester 0.
REQ-032 din values -128, 127, 0 -> dout_o -308224, 305816, 0.
REQ-033 rstn_i=0 after 4 accepted elements -> all outputs 0 next cycle; no done_o follows; the next req_i=10 is granted to requester 1 only after reset release.
